// File: rtl/core_mem_responder.sv
// Memory responder for the matrix core: host loads IM/DM, core gets 1-cycle registered reads, result region dumped after DONE_ADDR write.
// Load stalls while host_in_valid=0; dump holds data/valid stable while host_out_ready=0.
module core_mem_responder #(
  parameter int IM_DEPTH    = 256,
  parameter int DM_DEPTH    = 1024,
  parameter int IM_LOAD_LEN = 256,
  parameter int DM_LOAD_LEN = 512,
  parameter int DUMP_BASE   = 512,
  parameter int DUMP_LEN    = 256,
  parameter int DONE_ADDR   = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_im,
  input  logic [15:0] addr_dm,
  input  logic        im_wr,
  input  logic        dm_wr,
  input  logic [15:0] to_mem,
  output logic [7:0]  im_in,
  output logic [7:0]  dm_in,
  output logic        core_en,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  host_in_data,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  output logic [7:0]  host_out_data,
  output logic        host_out_valid,
  input  logic        host_out_ready
);
  localparam int IM_AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
  localparam int DM_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IM, S_LOAD_DM, S_RUN, S_DUMP, S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_core_en;
  logic [7:0]  r_im_q;
  logic [7:0]  r_dm_q;
  logic [7:0]  r_out_dat;
  logic        r_out_vld;
  logic [7:0]  r_im [IM_DEPTH];
  logic [7:0]  r_dm [DM_DEPTH];

  logic             w_run;
  logic             w_out_free;
  logic             w_done_wr;
  logic [7:0]       w_im_rdat;
  logic [31:0]      w_dm_raddr;
  logic [7:0]       w_dm_rdat;
  logic             w_im_we;
  logic [IM_AW-1:0] w_im_waddr;
  logic [7:0]       w_im_wdat;
  logic             w_dm_we;
  logic [DM_AW-1:0] w_dm_waddr;
  logic [7:0]       w_dm_wdat;
  logic             w_unused;

  assign w_run      = (r_state == S_RUN);
  assign w_out_free = !r_out_vld || host_out_ready;
  assign w_done_wr  = w_run && dm_wr && (32'(addr_dm) == 32'(DONE_ADDR));
  assign w_im_rdat  = (32'(addr_im) < 32'(IM_DEPTH)) ? r_im[addr_im[IM_AW-1:0]] : 8'h00;
  // A single DM read port serves both core reads and the dump prefetch
  assign w_dm_raddr = (r_state == S_DUMP) ? 32'(DUMP_BASE) + 32'(r_cnt) : 32'(addr_dm);
  assign w_dm_rdat  = (w_dm_raddr < 32'(DM_DEPTH)) ? r_dm[w_dm_raddr[DM_AW-1:0]] : 8'h00;
  assign w_unused   = ^to_mem[15:8];

  always_comb begin
    w_im_we    = 1'b0;
    w_im_waddr = r_cnt[IM_AW-1:0];
    w_im_wdat  = host_in_data;
    w_dm_we    = 1'b0;
    w_dm_waddr = r_cnt[DM_AW-1:0];
    w_dm_wdat  = host_in_data;
    if (r_state == S_LOAD_IM) begin
      w_im_we = host_in_valid;
    end else if (w_run && im_wr && (32'(addr_im) < 32'(IM_DEPTH))) begin
      w_im_we    = 1'b1;
      w_im_waddr = addr_im[IM_AW-1:0];
      w_im_wdat  = to_mem[7:0];
    end
    if (r_state == S_LOAD_DM) begin
      w_dm_we = host_in_valid;
    end else if (w_run && dm_wr && (32'(addr_dm) < 32'(DM_DEPTH))) begin
      w_dm_we    = 1'b1;
      w_dm_waddr = addr_dm[DM_AW-1:0];
      w_dm_wdat  = to_mem[7:0];
    end
  end

  // Arrays have no reset so contents survive aborts and completed jobs
  always_ff @(posedge clk) begin
    if (w_im_we) r_im[w_im_waddr] <= w_im_wdat;
    if (w_dm_we) r_dm[w_dm_waddr] <= w_dm_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_core_en <= 1'b0;
      r_im_q    <= 8'h00;
      r_dm_q    <= 8'h00;
      r_out_dat <= 8'h00;
      r_out_vld <= 1'b0;
    end else begin
      r_im_q <= 8'h00;
      r_dm_q <= 8'h00;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt <= '0;
            if (IM_LOAD_LEN != 0) begin
              r_state <= S_LOAD_IM;
            end else if (DM_LOAD_LEN != 0) begin
              r_state <= S_LOAD_DM;
            end else begin
              r_state   <= S_RUN;
              r_core_en <= 1'b1;
            end
          end
        end
        S_LOAD_IM: begin
          if (host_in_valid) begin
            if (r_cnt == 16'(IM_LOAD_LEN - 1)) begin
              r_cnt <= '0;
              if (DM_LOAD_LEN != 0) begin
                r_state <= S_LOAD_DM;
              end else begin
                r_state   <= S_RUN;
                r_core_en <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_LOAD_DM: begin
          if (host_in_valid) begin
            if (r_cnt == 16'(DM_LOAD_LEN - 1)) begin
              r_cnt     <= '0;
              r_state   <= S_RUN;
              r_core_en <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_RUN: begin
          if (w_done_wr) begin
            r_core_en <= 1'b0;
            r_cnt     <= '0;
            r_state   <= (DUMP_LEN != 0) ? S_DUMP : S_DONE;
          end else begin
            r_im_q <= w_im_rdat;
            r_dm_q <= w_dm_rdat;
          end
        end
        S_DUMP: begin
          // The output register doubles as the read register: refill only when it drains
          if (w_out_free) begin
            if (32'(r_cnt) < 32'(DUMP_LEN)) begin
              r_out_dat <= w_dm_rdat;
              r_out_vld <= 1'b1;
              r_cnt     <= r_cnt + 16'd1;
            end else begin
              r_out_vld <= 1'b0;
              r_state   <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign im_in          = r_im_q;
  assign dm_in          = r_dm_q;
  assign core_en        = r_core_en;
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign host_in_ready  = (r_state == S_LOAD_IM) || (r_state == S_LOAD_DM);
  assign host_out_data  = r_out_dat;
  assign host_out_valid = r_out_vld;
endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: small-parameter instance for load/run/dump/abort, second instance for
// skipped IM load and a dump window running past the end of DM.
module tb_core_mem_responder;
  localparam int IM_D   = 16;
  localparam int DM_D   = 32;
  localparam int DONE_A = 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_im = '0, addr_dm = '0, to_mem = '0;
  logic        im_wr = 1'b0, dm_wr = 1'b0, start = 1'b0;
  logic [7:0]  host_in_data = '0;
  logic        host_in_valid = 1'b0, host_out_ready = 1'b0;
  logic [7:0]  im_in, dm_in, host_out_data;
  logic        core_en, busy, done, host_in_ready, host_out_valid;

  logic [15:0] b_addr_im = '0, b_addr_dm = '0, b_to_mem = '0;
  logic        b_im_wr = 1'b0, b_dm_wr = 1'b0, b_start = 1'b0;
  logic [7:0]  b_host_in_data = '0;
  logic        b_host_in_valid = 1'b0, b_host_out_ready = 1'b0;
  logic [7:0]  b_im_in, b_dm_in, b_host_out_data;
  logic        b_core_en, b_busy, b_done, b_host_in_ready, b_host_out_valid;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_mem_responder #(.IM_DEPTH(IM_D), .DM_DEPTH(DM_D), .IM_LOAD_LEN(4), .DM_LOAD_LEN(4),
                       .DUMP_BASE(0), .DUMP_LEN(4), .DONE_ADDR(DONE_A)) u_a (
    .clk(clk), .rst_n(rst_n), .addr_im(addr_im), .addr_dm(addr_dm), .im_wr(im_wr), .dm_wr(dm_wr),
    .to_mem(to_mem), .im_in(im_in), .dm_in(dm_in), .core_en(core_en), .start(start), .busy(busy),
    .done(done), .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready), .host_out_data(host_out_data), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready));

  core_mem_responder #(.IM_DEPTH(IM_D), .DM_DEPTH(DM_D), .IM_LOAD_LEN(0), .DM_LOAD_LEN(2),
                       .DUMP_BASE(30), .DUMP_LEN(4), .DONE_ADDR(DONE_A)) u_b (
    .clk(clk), .rst_n(rst_n), .addr_im(b_addr_im), .addr_dm(b_addr_dm), .im_wr(b_im_wr),
    .dm_wr(b_dm_wr), .to_mem(b_to_mem), .im_in(b_im_in), .dm_in(b_dm_in), .core_en(b_core_en),
    .start(b_start), .busy(b_busy), .done(b_done), .host_in_data(b_host_in_data),
    .host_in_valid(b_host_in_valid), .host_in_ready(b_host_in_ready),
    .host_out_data(b_host_out_data), .host_out_valid(b_host_out_valid),
    .host_out_ready(b_host_out_ready));

  // Reference memory contents; k_* marks bytes whose value is known
  logic [7:0] m_im [IM_D];
  logic [7:0] m_dm [DM_D];
  bit         k_im [IM_D];
  bit         k_dm [DM_D];
  logic [7:0] ld_q [$];
  logic [6:0] pat = 7'b1011001;

  typedef struct packed {
    logic iw; logic dw; logic [15:0] ai; logic [15:0] ad; logic [15:0] tm;
    logic [7:0] ei; logic [7:0] ed;
  } vec_t;
  vec_t tv [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ref_im(input logic [15:0] a);
    if (a >= 16'(IM_D)) return {1'b1, 8'h00};
    return {k_im[a[3:0]], m_im[a[3:0]]};
  endfunction

  function automatic logic [8:0] ref_dm(input logic [15:0] a);
    if (a >= 16'(DM_D)) return {1'b1, 8'h00};
    return {k_dm[a[4:0]], m_dm[a[4:0]]};
  endfunction

  task automatic model_wr(input logic iw, input logic dw, input logic [15:0] ai,
                          input logic [15:0] ad, input logic [7:0] d);
    if (iw && ai < 16'(IM_D)) begin m_im[ai[3:0]] = d; k_im[ai[3:0]] = 1'b1; end
    if (dw && ad < 16'(DM_D)) begin m_dm[ad[4:0]] = d; k_dm[ad[4:0]] = 1'b1; end
  endtask

  task automatic core_access(input string nm, input logic iw, input logic dw,
                             input logic [15:0] ai, input logic [15:0] ad, input logic [15:0] tm);
    logic [8:0] ei, ed;
    ei = ref_im(ai);
    ed = ref_dm(ad);
    im_wr = iw; dm_wr = dw; addr_im = ai; addr_dm = ad; to_mem = tm;
    step();
    if (ei[8]) chk({nm, "_im"}, im_in, ei[7:0]);
    if (ed[8]) chk({nm, "_dm"}, dm_in, ed[7:0]);
    model_wr(iw, dw, ai, ad, tm[7:0]);
    im_wr = 1'b0; dm_wr = 1'b0;
  endtask

  // Streams ld_q (4 IM bytes then 4 DM bytes); core write strobes are driven and must be ignored
  task automatic load_a(input bit rnd);
    int idx, cyc;
    bit ph;
    idx = 0; cyc = 0; ph = 1'b1;
    while (idx < 8 && cyc < 200) begin
      host_in_valid = rnd ? 1'($urandom_range(0, 1)) : ph;
      ph = ~ph;
      host_in_data = host_in_valid ? ld_q[idx] : 8'($urandom);
      im_wr = 1'b1; dm_wr = 1'b1; to_mem = 16'($urandom);
      addr_im = 16'($urandom_range(4, IM_D - 1));
      addr_dm = 16'($urandom_range(4, DM_D - 2));
      chk("load_in_ready", host_in_ready, 1);
      if (idx == 7 && host_in_valid) chk("core_en_before_last", core_en, 0);
      step();
      chk("load_rd_zero", {im_in, dm_in}, 0);
      cyc++;
      if (host_in_valid) begin
        if (idx < 4) begin m_im[4'(idx)] = ld_q[idx]; k_im[4'(idx)] = 1'b1; end
        else begin m_dm[5'(idx - 4)] = ld_q[idx]; k_dm[5'(idx - 4)] = 1'b1; end
        idx++;
      end
    end
    host_in_valid = 1'b0; im_wr = 1'b0; dm_wr = 1'b0;
    chk("load_accepted", idx, 8);
    chk("core_en_after_load", {core_en, busy}, 2'b11);
  endtask

  task automatic finish_run();
    dm_wr = 1'b1; addr_dm = 16'(DONE_A); to_mem = 16'h0001;
    step();
    dm_wr = 1'b0;
    model_wr(1'b0, 1'b1, 16'h0, 16'(DONE_A), 8'h01);
    chk("done_wr_core_en", core_en, 0);
    chk("done_wr_dump_state", {busy, done, dm_in}, {2'b10, 8'h00});
  endtask

  task automatic dump_a(input bit rnd);
    logic [7:0] exp_q [$];
    logic [7:0] held;
    bit stalled;
    int n, cyc, first;
    for (int i = 0; i < 4; i++) exp_q.push_back(m_dm[5'(i)]);
    n = 0; cyc = 0; first = -1; stalled = 1'b0; held = '0;
    while (!done && cyc < 100) begin
      host_out_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc < 7) ? pat[3'(cyc)] : 1'b1);
      if (stalled) begin
        chk("dump_valid_held", host_out_valid, 1);
        chk("dump_data_stable", host_out_data, held);
      end
      stalled = 1'b0;
      if (host_out_valid) begin
        if (first < 0) first = cyc;
        if (host_out_ready) begin
          if (n < exp_q.size()) chk($sformatf("dump_byte%0d", n), host_out_data, exp_q[n]);
          else chk("dump_extra_byte", n, exp_q.size());
          n++;
        end else begin
          stalled = 1'b1;
          held = host_out_data;
        end
      end
      step();
      cyc++;
    end
    host_out_ready = 1'b0;
    chk("dump_count", n, exp_q.size());
    chk("dump_first_valid_le2", (first >= 0 && first <= 2), 1);
    chk("dump_end_state", {done, busy, host_out_valid, core_en}, 4'b1000);
  endtask

  initial begin
    tv[0] = '{1'b0, 1'b0, 16'd0,  16'd2,  16'h0000, 8'h11, 8'hA2};
    tv[1] = '{1'b0, 1'b1, 16'd1,  16'd2,  16'hBEEF, 8'h22, 8'hA2};
    tv[2] = '{1'b0, 1'b0, 16'd2,  16'd2,  16'h0000, 8'h33, 8'hEF};
    tv[3] = '{1'b0, 1'b0, 16'd3,  16'd32, 16'h0000, 8'h44, 8'h00};
    tv[4] = '{1'b1, 1'b0, 16'd3,  16'd3,  16'h1255, 8'h44, 8'hA3};
    tv[5] = '{1'b0, 1'b0, 16'd3,  16'd0,  16'h0000, 8'h55, 8'hA0};
    tv[6] = '{1'b1, 1'b1, 16'd16, 16'd32, 16'h0077, 8'h00, 8'h00};
    tv[7] = '{1'b0, 1'b0, 16'd0,  16'd0,  16'h0000, 8'h11, 8'hA0};

    // Reset with random inputs, then idle without start
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); host_in_valid = 1'($urandom); host_out_ready = 1'($urandom);
      addr_im = 16'($urandom); addr_dm = 16'($urandom); host_in_data = 8'($urandom);
      step();
      chk("reset_outputs", {im_in, dm_in, core_en, busy, done, host_in_ready,
                            host_out_valid, host_out_data}, 0);
    end
    start = 1'b0; host_out_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_in_valid = 1'($urandom);
      step();
      chk("idle_no_start", {im_in, dm_in, core_en, busy, done, host_in_ready, host_out_valid}, 0);
    end
    host_in_valid = 1'b0;

    // Job 1: toggling-valid load, table vectors, random core traffic, done, patterned dump
    start = 1'b1; step(); start = 1'b0;
    chk("start_to_load", {busy, done, host_in_ready}, 3'b101);
    ld_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    load_a(1'b0);
    for (int i = 0; i < 8; i++) begin
      im_wr = tv[i].iw; dm_wr = tv[i].dw; addr_im = tv[i].ai; addr_dm = tv[i].ad; to_mem = tv[i].tm;
      step();
      chk($sformatf("vec%0d_im", i), im_in, tv[i].ei);
      chk($sformatf("vec%0d_dm", i), dm_in, tv[i].ed);
      model_wr(tv[i].iw, tv[i].dw, tv[i].ai, tv[i].ad, tv[i].tm[7:0]);
    end
    im_wr = 1'b0; dm_wr = 1'b0;
    for (int c = 0; c < 300; c++) begin
      logic iw, dw;
      logic [15:0] ai, ad;
      iw = ($urandom_range(0, 3) == 0);
      dw = ($urandom_range(0, 1) == 0);
      ai = 16'($urandom_range(0, IM_D + 3));
      ad = 16'($urandom_range(0, DM_D + 3));
      if (ad < 16'd4 || ad == 16'(DONE_A)) dw = 1'b0;
      core_access("rnd", iw, dw, ai, ad, 16'($urandom));
    end
    chk("core_en_in_run", core_en, 1);
    finish_run();
    dump_a(1'b0);

    // Restart from DONE, abort in LOAD_DM, then a full job with random valid/ready
    start = 1'b1; step(); start = 1'b0;
    chk("restart_from_done", {busy, done, host_in_ready}, 3'b101);
    host_in_valid = 1'b1;
    ld_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h71};
    for (int i = 0; i < 5; i++) begin
      host_in_data = ld_q[i];
      step();
      if (i < 4) begin m_im[4'(i)] = ld_q[i]; k_im[4'(i)] = 1'b1; end
      else begin m_dm[0] = ld_q[i]; k_dm[0] = 1'b1; end
    end
    host_in_valid = 1'b0;
    chk("abort_in_load_dm", {host_in_ready, core_en, busy}, 3'b101);
    #2 rst_n = 1'b0;
    #1 chk("async_abort", {busy, host_in_ready, core_en, done, host_out_valid}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_after_abort", {busy, done, host_in_ready}, 0);
    start = 1'b1; step(); start = 1'b0;
    ld_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h91, 8'h92, 8'h93, 8'h94};
    load_a(1'b1);
    for (int i = 0; i < DM_D; i++) core_access("sweep", 1'b0, 1'b0, 16'(i), 16'(i), 16'h0);
    finish_run();
    dump_a(1'b1);

    // Instance B: IM load skipped, dump window DM[30..33] with the last two beyond DM
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_skip_im_load", {b_host_in_ready, b_busy, b_core_en}, 3'b110);
    b_host_in_valid = 1'b1;
    b_host_in_data = 8'hC0; step();
    chk("b_core_en_early", b_core_en, 0);
    b_host_in_data = 8'hC1; step();
    b_host_in_valid = 1'b0;
    chk("b_core_en_after_load", b_core_en, 1);
    b_addr_dm = 16'd0; step(); chk("b_dm0", b_dm_in, 8'hC0);
    b_addr_dm = 16'd1; step(); chk("b_dm1", b_dm_in, 8'hC1);
    b_dm_wr = 1'b1; b_addr_dm = 16'd30; b_to_mem = 16'h215A; step();
    b_addr_dm = 16'(DONE_A); b_to_mem = 16'h3377; step();
    b_dm_wr = 1'b0;
    chk("b_done_wr", {b_core_en, b_busy, b_done}, 3'b010);
    begin
      logic [7:0] b_exp [4];
      int n, cyc, first_c, last_c;
      b_exp = '{8'h5A, 8'h77, 8'h00, 8'h00};
      n = 0; cyc = 0; first_c = -1; last_c = -1;
      b_host_out_ready = 1'b1;
      while (!b_done && cyc < 40) begin
        if (b_host_out_valid) begin
          if (n < 4) chk($sformatf("b_dump_byte%0d", n), b_host_out_data, b_exp[2'(n)]);
          else chk("b_dump_extra_byte", n, 4);
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          n++;
        end
        step();
        cyc++;
      end
      b_host_out_ready = 1'b0;
      chk("b_dump_count", n, 4);
      chk("b_dump_back_to_back", last_c - first_c, 3);
      chk("b_dump_end_state", {b_done, b_busy, b_host_out_valid}, 3'b100);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end
endmodule
